bf_control_unit: RTL and testbench
==================================

Name: bf_control_unit

Overview:
- Instruction sequencer for the BF machine; sits directly upstream of the PC, data-pointer and data ALUs and the data-source mux.
- Decodes the byte at the current PC and drives their enable/direction/select strobes.
- Performs bracket matching by PC scanning with a depth counter.
- Runs the byte I/O handshakes and halts on 0x00.

Parameters:
- DEPTH_W, 8, width of the bracket nesting-depth counter.
- PC_W, 8, program-counter width; matches the 8-bit ALUs.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse; leaves IDLE.
- instr  input  8  program byte at current PC (combinational memory read).
- pc  input  PC_W  current PC value (wrap detection during backward scan).
- data  input  8  data byte at current data pointer (combinational read).
- pc_en  output  1  PC register load from PC ALU this cycle.
- pc_dec  output  1  PC ALU direction; 1 = decrement.
- dp_en  output  1  data-pointer load.
- dp_dec  output  1  data-pointer ALU direction.
- d_we  output  1  data-memory write.
- d_dec  output  1  data ALU direction.
- d_sel  output  1  data mux select; 0 = data ALU, 1 = in_data.
- in_valid  input  1  input byte available.
- in_ready  output  1  controller accepts input byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts out_data.
- out_data  output  8  registered output byte.
- busy  output  1  high in any state except IDLE and HALT.
- halted  output  1  registered, sticky.
- error  output  1  registered, sticky; unmatched bracket or depth overflow.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, depth=0, out_data=0x00.
  - halted, error and all strobes/valid/ready = 0.
- Strobes are combinational from state+instr+data. All other registers update on the rising clk edge.
- States: IDLE, EXEC, SCAN_FWD, SCAN_BACK, WAIT_IN, WAIT_OUT, HALT.
- IDLE: start=1 -> EXEC. No strobes.
- EXEC: one instruction per cycle, by opcode:
  - '+' 0x2B: d_we=1, d_dec=0, pc_en=1.
  - '-' 0x2D: d_we=1, d_dec=1, pc_en=1.
  - '>' 0x3E: dp_en=1, dp_dec=0, pc_en=1.
  - '<' 0x3C: dp_en=1, dp_dec=1, pc_en=1.
  - '[' 0x5B, data!=0: pc_en=1.
  - '[' 0x5B, data==0: pc_en=1, depth<=1, -> SCAN_FWD.
  - ']' 0x5D, data==0: pc_en=1.
  - ']' 0x5D, data!=0: pc_en=1, pc_dec=1, depth<=1, -> SCAN_BACK.
  - '.' 0x2E: out_data<=data, -> WAIT_OUT (PC held).
  - ',' 0x2C: -> WAIT_IN (PC held).
  - 0x00: -> HALT, halted<=1.
  - Any other byte: NOP, pc_en=1.
- SCAN_FWD (PC incrementing), acting on instr each cycle:
  - '[': depth++, pc_en.
  - ']' with depth==1: depth<=0, pc_en, -> EXEC; the PC lands after the matching ']'.
  - ']' otherwise: depth--, pc_en.
  - 0x00: error<=1, halted<=1, -> HALT.
  - Else: pc_en.
- SCAN_BACK (pc_dec=1 for every decrement), acting on instr each cycle:
  - ']': depth++, decrement.
  - '[' with depth==1: pc_en with pc_dec=0, -> EXEC; the PC lands after the matching '['.
  - '[' otherwise: depth--, decrement.
  - pc==0 and no match this cycle: error, halt.
  - Else: decrement.
- Depth at all-ones when incrementing -> error, halt; no wrap.
- WAIT_IN: in_ready=1, d_sel=1. When in_valid=1: d_we=1, pc_en=1, -> EXEC.
- WAIT_OUT: out_valid=1, out_data stable. When out_ready=1: pc_en=1, -> EXEC.
- Transfer rules: transfer only on valid&&ready in the same cycle. No combinational path from in_valid to in_ready or from out_ready to out_valid.
- HALT is absorbing until reset; start is ignored there. start is also ignored outside IDLE.
- Reset mid-scan or mid-handshake returns to IDLE immediately; a pending out_valid drops asynchronously.

Optional Feature:
- Macro: BF_RETIRE_COUNT_EN.
- Defined:
  - Adds output retired[31:0], reset 0.
  - Increments once per completed instruction: each EXEC cycle with pc_en, each scan exit to EXEC, each handshake completion.
  - Saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package bf_pkg:
  - Opcode constants (OP_INC, OP_DEC, OP_RIGHT, OP_LEFT, OP_LOOP, OP_END, OP_OUT, OP_IN, OP_HALT).
  - State enum typedef.
  - Default widths.
- One sub-module, bf_depth_counter: load-1/inc/dec with overflow and at-one flags.

Test Plan:
- Program "++>-." with out_ready=1 → d_we in cycles 1,2 (d_dec=0), dp_en with dp_dec=0 in cycle 3, d_we with d_dec=1 in cycle 4; WAIT_OUT with out_data=data, then halted on 0x00.
- '[' at PC 0x00, data=0, program "[+[-]]." → SCAN_FWD with depth 1,2,1, exits with pc_en after the ']' at 0x05; EXEC resumes at PC 0x06.
- ']' at PC 0x04, data=5, program "[+[-]" with '[' at 0x00 and 0x02 → SCAN_BACK, matches the '[' at 0x02 with depth==1, PC set to 0x03.
- ',' with in_valid held low 3 cycles, then 0x41 → in_ready high for 4 cycles; d_we=1, d_sel=1 only in the accept cycle.
- Unmatched '[' followed by 0x00 with data=0 → error=1, halted=1, busy=0.
- Reset asserted during WAIT_OUT → out_valid=0 immediately; state IDLE after release.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared opcodes, state encoding and default widths for the BF sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bf_pkg;

    localparam int DEPTH_W_DEF = 8;
    localparam int PC_W_DEF    = 8;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_LOOP  = 8'h5B;
    localparam logic [7:0] OP_END   = 8'h5D;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_HALT  = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        SCAN_FWD,
        SCAN_BACK,
        WAIT_IN,
        WAIT_OUT,
        HALT
    } state_t;

endpackage

// File: rtl/bf_depth_counter.sv
// Bracket nesting-depth counter with load-one, clear, increment and decrement.
// Latency: one cycle from command to new count; flags are combinational from the count.
// Backpressure: none; the caller must not increment when at_max is set.
module bf_depth_counter #(
    parameter int DEPTH_W = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_one,
    input  logic clear,
    input  logic inc,
    input  logic dec,
    output logic at_one,
    output logic at_max
);

    logic [DEPTH_W-1:0] depth;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth <= '0;
        end else if (clear) begin
            depth <= '0;
        end else if (load_one) begin
            depth <= {{(DEPTH_W-1){1'b0}}, 1'b1};
        end else if (inc) begin
            depth <= depth + 1'b1;
        end else if (dec) begin
            depth <= depth - 1'b1;
        end
    end

    assign at_one = (depth == {{(DEPTH_W-1){1'b0}}, 1'b1});
    assign at_max = &depth;

endmodule

// File: rtl/bf_control_unit.sv
// BF instruction sequencer: decodes instr, drives ALU/mux strobes, scans brackets, runs byte I/O.
// Latency: one instruction per cycle in EXEC; scans take one cycle per byte; strobes are combinational.
// Backpressure: stalls in WAIT_IN/WAIT_OUT until in_valid/out_ready; BF_RETIRE_COUNT_EN adds retired.
module bf_control_unit
    import bf_pkg::*;
#(
    parameter int DEPTH_W = DEPTH_W_DEF,
    parameter int PC_W    = PC_W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [7:0]      instr,
    input  logic [PC_W-1:0] pc,
    input  logic [7:0]      data,
    output logic            pc_en,
    output logic            pc_dec,
    output logic            dp_en,
    output logic            dp_dec,
    output logic            d_we,
    output logic            d_dec,
    output logic            d_sel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            busy,
    output logic            halted,
    output logic            error
`ifdef BF_RETIRE_COUNT_EN
    ,
    output logic [31:0]     retired
`endif
);

    state_t state, next_state;
    logic   dc_load, dc_clear, dc_inc, dc_dec;
    logic   at_one, at_max;
    logic   set_halt, set_err, load_out;

    bf_depth_counter #(.DEPTH_W(DEPTH_W)) u_depth (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_one (dc_load),
        .clear    (dc_clear),
        .inc      (dc_inc),
        .dec      (dc_dec),
        .at_one   (at_one),
        .at_max   (at_max)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            halted   <= 1'b0;
            error    <= 1'b0;
            out_data <= 8'h00;
        end else begin
            state <= next_state;
            if (set_halt) halted <= 1'b1;
            if (set_err)  error  <= 1'b1;
            if (load_out) out_data <= data;
        end
    end

    always_comb begin
        next_state = state;
        pc_en      = 1'b0;
        pc_dec     = 1'b0;
        dp_en      = 1'b0;
        dp_dec     = 1'b0;
        d_we       = 1'b0;
        d_dec      = 1'b0;
        d_sel      = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        dc_load    = 1'b0;
        dc_clear   = 1'b0;
        dc_inc     = 1'b0;
        dc_dec     = 1'b0;
        set_halt   = 1'b0;
        set_err    = 1'b0;
        load_out   = 1'b0;
        case (state)
            IDLE: if (start) next_state = EXEC;
            EXEC: begin
                case (instr)
                    OP_INC:   begin d_we = 1'b1; pc_en = 1'b1; end
                    OP_DEC:   begin d_we = 1'b1; d_dec = 1'b1; pc_en = 1'b1; end
                    OP_RIGHT: begin dp_en = 1'b1; pc_en = 1'b1; end
                    OP_LEFT:  begin dp_en = 1'b1; dp_dec = 1'b1; pc_en = 1'b1; end
                    OP_LOOP: begin
                        pc_en = 1'b1;
                        if (data == 8'h00) begin
                            dc_load    = 1'b1;
                            next_state = SCAN_FWD;
                        end
                    end
                    OP_END: begin
                        pc_en = 1'b1;
                        if (data != 8'h00) begin
                            pc_dec     = 1'b1;
                            dc_load    = 1'b1;
                            next_state = SCAN_BACK;
                        end
                    end
                    OP_OUT:  begin load_out = 1'b1; next_state = WAIT_OUT; end
                    OP_IN:   next_state = WAIT_IN;
                    OP_HALT: begin set_halt = 1'b1; next_state = HALT; end
                    default: pc_en = 1'b1;
                endcase
            end
            SCAN_FWD: begin
                case (instr)
                    OP_LOOP: begin
                        if (at_max) begin
                            set_err = 1'b1; set_halt = 1'b1; next_state = HALT;
                        end else begin
                            dc_inc = 1'b1; pc_en = 1'b1;
                        end
                    end
                    OP_END: begin
                        pc_en = 1'b1;
                        if (at_one) begin
                            dc_clear   = 1'b1;
                            next_state = EXEC;
                        end else begin
                            dc_dec = 1'b1;
                        end
                    end
                    OP_HALT: begin set_err = 1'b1; set_halt = 1'b1; next_state = HALT; end
                    default: pc_en = 1'b1;
                endcase
            end
            SCAN_BACK: begin
                // A match at PC 0 is still legal; only a miss there is fatal.
                if (instr == OP_LOOP && at_one) begin
                    pc_en      = 1'b1;
                    dc_clear   = 1'b1;
                    next_state = EXEC;
                end else if (pc == '0) begin
                    set_err = 1'b1; set_halt = 1'b1; next_state = HALT;
                end else if (instr == OP_END && at_max) begin
                    set_err = 1'b1; set_halt = 1'b1; next_state = HALT;
                end else begin
                    pc_en  = 1'b1;
                    pc_dec = 1'b1;
                    dc_inc = (instr == OP_END);
                    dc_dec = (instr == OP_LOOP);
                end
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                d_sel    = 1'b1;
                if (in_valid) begin
                    d_we = 1'b1; pc_en = 1'b1; next_state = EXEC;
                end
            end
            WAIT_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pc_en = 1'b1; next_state = EXEC;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != HALT);

`ifdef BF_RETIRE_COUNT_EN
    // Every completed instruction advances the PC and either stays in or returns to EXEC.
    logic retire;
    assign retire = pc_en && ((state == EXEC) || (next_state == EXEC));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired <= 32'h0;
        end else if (retire && (retired != 32'hFFFF_FFFF)) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bf_control_unit.sv
// Directed bench for bf_control_unit with a behavioural PC/DP/data-memory harness around it.
module tb_bf_control_unit;
    import bf_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] instr, pc, data;
    logic       pc_en, pc_dec, dp_en, dp_dec, d_we, d_dec, d_sel;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] out_data;
    logic       busy, halted, error;
`ifdef BF_RETIRE_COUNT_EN
    logic [31:0] retired;
`endif

    logic [7:0] prog [256];
    logic [7:0] dmem [256];
    logic [7:0] pc_r, dp_r, in_byte;
    int n_checks = 0;
    int n_fail   = 0;

    assign instr = prog[pc_r];
    assign data  = dmem[dp_r];
    assign pc    = pc_r;

    bf_control_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .pc(pc), .data(data),
        .pc_en(pc_en), .pc_dec(pc_dec), .dp_en(dp_en), .dp_dec(dp_dec),
        .d_we(d_we), .d_dec(d_dec), .d_sel(d_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .halted(halted), .error(error)
`ifdef BF_RETIRE_COUNT_EN
        , .retired(retired)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called just after a negedge; applies this cycle's strobes to the harness after the posedge.
    task automatic step();
        logic s_pc_en, s_pc_dec, s_dp_en, s_dp_dec, s_we, s_dd, s_sel;
        logic [7:0] s_data, s_dp, s_in;
        s_pc_en = pc_en; s_pc_dec = pc_dec; s_dp_en = dp_en; s_dp_dec = dp_dec;
        s_we = d_we; s_dd = d_dec; s_sel = d_sel; s_data = data; s_dp = dp_r; s_in = in_byte;
        @(posedge clk);
        #1;
        if (s_pc_en) pc_r = s_pc_dec ? pc_r - 8'd1 : pc_r + 8'd1;
        if (s_dp_en) dp_r = s_dp_dec ? dp_r - 8'd1 : dp_r + 8'd1;
        if (s_we)    dmem[s_dp] = s_sel ? s_in : (s_dd ? s_data - 8'd1 : s_data + 8'd1);
        @(negedge clk);
    endtask

    task automatic init(input string p, input logic [7:0] pc0, input logic [7:0] d0);
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_byte = 8'h00;
        for (int i = 0; i < 256; i++) begin
            prog[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        for (int i = 0; i < p.len(); i++) prog[i] = p[i];
        pc_r = pc0; dp_r = 8'h00; dmem[0] = d0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic go();
        start = 1'b1;
        #1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        init("", 8'h00, 8'h00);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({pc_en, pc_dec, dp_en, dp_dec, d_we, d_dec, d_sel, in_ready, out_valid, busy, halted, error} !== 12'h000) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 000000000000",
                {pc_en, pc_dec, dp_en, dp_dec, d_we, d_dec, d_sel, in_ready, out_valid, busy, halted, error});
        end
        n_checks++;
        if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        #1;
        n_checks++;
        if (dut.state !== IDLE || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: got state %0d busy %b want state 0 busy 0", dut.state, busy);
        end
`ifdef BF_RETIRE_COUNT_EN
        n_checks++;
        if (retired !== 32'h0) begin n_fail++; $display("FAIL reset_retired: got %h want 0", retired); end
`endif
    endtask

    task automatic test_program();
        init("++>-.", 8'h00, 8'h00);
        out_ready = 1'b1;
        go();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if ({d_we, d_dec, pc_en, dp_en} !== 4'b1010) begin
                n_fail++; $display("FAIL prog_inc%0d: got %b want 1010", i, {d_we, d_dec, pc_en, dp_en});
            end
            step();
        end
        #1;
        n_checks++;
        if ({d_we, pc_en, dp_en, dp_dec} !== 4'b0110) begin
            n_fail++; $display("FAIL prog_right: got %b want 0110", {d_we, pc_en, dp_en, dp_dec});
        end
        step();
        #1;
        n_checks++;
        if ({d_we, d_dec, pc_en, dp_en} !== 4'b1110) begin
            n_fail++; $display("FAIL prog_dec: got %b want 1110", {d_we, d_dec, pc_en, dp_en});
        end
        step();
        #1;
        n_checks++;
        if ({pc_en, out_valid, busy} !== 3'b001) begin
            n_fail++; $display("FAIL prog_out_exec: got %b want 001", {pc_en, out_valid, busy});
        end
        step();
        #1;
        n_checks++;
        if ({out_valid, pc_en} !== 2'b11 || out_data !== 8'hFF) begin
            n_fail++; $display("FAIL prog_wait_out: got vld/pc_en %b data %h want 11 ff", {out_valid, pc_en}, out_data);
        end
        step();
        #1;
        n_checks++;
        if (pc_r !== 8'h05 || {busy, halted} !== 2'b10) begin
            n_fail++; $display("FAIL prog_at_halt_op: got pc %h busy/halted %b want 05 10", pc_r, {busy, halted});
        end
        step();
        #1;
        n_checks++;
        if ({busy, halted, error} !== 3'b010 || dmem[0] !== 8'h02) begin
            n_fail++; $display("FAIL prog_halted: got %b mem0 %h want 010 02", {busy, halted, error}, dmem[0]);
        end
`ifdef BF_RETIRE_COUNT_EN
        n_checks++;
        if (retired !== 32'd5) begin n_fail++; $display("FAIL prog_retired: got %0d want 5", retired); end
`endif
    endtask

    task automatic test_scan_fwd();
        logic [7:0] exp_d [5];
        exp_d = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd1};
        init("[+[-]].", 8'h00, 8'h00);
        go();
        #1;
        n_checks++;
        if ({pc_en, pc_dec, d_we} !== 3'b100) begin
            n_fail++; $display("FAIL fwd_enter: got %b want 100", {pc_en, pc_dec, d_we});
        end
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (dut.u_depth.depth !== exp_d[i] || {pc_en, pc_dec, d_we} !== 3'b100 || pc_r !== 8'(i + 1)) begin
                n_fail++; $display("FAIL fwd_scan%0d: got depth %0d strobes %b pc %h want %0d 100 %h",
                    i, dut.u_depth.depth, {pc_en, pc_dec, d_we}, pc_r, exp_d[i], 8'(i + 1));
            end
            step();
        end
        #1;
        n_checks++;
        if (pc_r !== 8'h06 || dut.u_depth.depth !== 8'd0 || {busy, pc_en} !== 2'b10) begin
            n_fail++; $display("FAIL fwd_exit: got pc %h depth %0d busy/pc_en %b want 06 0 10",
                pc_r, dut.u_depth.depth, {busy, pc_en});
        end
    endtask

    task automatic test_scan_back();
        init("[+[-]", 8'h04, 8'h05);
        go();
        #1;
        n_checks++;
        if ({pc_en, pc_dec} !== 2'b11) begin
            n_fail++; $display("FAIL back_enter: got %b want 11", {pc_en, pc_dec});
        end
        step();
        #1;
        n_checks++;
        if (pc_r !== 8'h03 || dut.u_depth.depth !== 8'd1 || {pc_en, pc_dec} !== 2'b11) begin
            n_fail++; $display("FAIL back_scan: got pc %h depth %0d strobes %b want 03 1 11",
                pc_r, dut.u_depth.depth, {pc_en, pc_dec});
        end
        step();
        #1;
        n_checks++;
        if (pc_r !== 8'h02 || {pc_en, pc_dec} !== 2'b10) begin
            n_fail++; $display("FAIL back_match: got pc %h strobes %b want 02 10", pc_r, {pc_en, pc_dec});
        end
        step();
        #1;
        n_checks++;
        if (pc_r !== 8'h03 || dut.u_depth.depth !== 8'd0 || {busy, d_we, d_dec} !== 3'b111) begin
            n_fail++; $display("FAIL back_resume: got pc %h depth %0d strobes %b want 03 0 111",
                pc_r, dut.u_depth.depth, {busy, d_we, d_dec});
        end
    endtask

    task automatic test_input();
        init(",", 8'h00, 8'h00);
        go();
        #1;
        n_checks++;
        if ({in_ready, pc_en} !== 2'b00) begin
            n_fail++; $display("FAIL in_exec: got %b want 00", {in_ready, pc_en});
        end
        step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            #1;
            n_checks++;
            if ({in_ready, d_we, pc_en} !== 3'b100) begin
                n_fail++; $display("FAIL in_wait%0d: got %b want 100", i, {in_ready, d_we, pc_en});
            end
            step();
        end
        in_valid = 1'b1;
        in_byte  = 8'h41;
        #1;
        n_checks++;
        if ({in_ready, d_we, d_sel, pc_en} !== 4'b1111) begin
            n_fail++; $display("FAIL in_accept: got %b want 1111", {in_ready, d_we, d_sel, pc_en});
        end
        step();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, d_sel} !== 2'b00 || dmem[0] !== 8'h41 || pc_r !== 8'h01) begin
            n_fail++; $display("FAIL in_done: got rdy/sel %b mem0 %h pc %h want 00 41 01", {in_ready, d_sel}, dmem[0], pc_r);
        end
    endtask

    task automatic test_unmatched();
        init("[", 8'h00, 8'h00);
        go();
        step();
        #1;
        n_checks++;
        if ({busy, error, pc_en} !== 3'b100) begin
            n_fail++; $display("FAIL unm_scan: got %b want 100", {busy, error, pc_en});
        end
        step();
        #1;
        n_checks++;
        if ({error, halted, busy} !== 3'b110) begin
            n_fail++; $display("FAIL unm_halt: got %b want 110", {error, halted, busy});
        end
        start = 1'b1;
        #1;
        step();
        start = 1'b0;
        #1;
        n_checks++;
        if (dut.state !== HALT || {busy, halted, error} !== 3'b011) begin
            n_fail++; $display("FAIL unm_absorb: got state %0d flags %b want 6 011", dut.state, {busy, halted, error});
        end
    endtask

    task automatic test_reset_wait_out();
        init(".", 8'h00, 8'h5A);
        go();
        step();
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || pc_en !== 1'b0) begin
            n_fail++; $display("FAIL wo_stall: got vld %b data %h pc_en %b want 1 5a 0", out_valid, out_data, pc_en);
        end
        step();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL wo_async_reset: got vld %b data %h busy %b want 0 00 0", out_valid, out_data, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        #1;
        n_checks++;
        if (dut.state !== IDLE || {busy, out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL wo_idle: got state %0d busy/vld %b want 0 00", dut.state, {busy, out_valid});
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_scan_fwd();
        test_scan_back();
        test_input();
        test_unmatched();
        test_reset_wait_out();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
